// File: rtl/regfile_wr_arbiter_if.sv
// Requester, register-file write-port and read-monitor signals of the writeback arbiter.
// The master side is whoever drives requests and read addresses; the slave side is the arbiter.
interface regfile_wr_arbiter_if #(
  parameter int NREQ = 3,
  parameter int PTRW = 3
);
  logic                 Stall;
  logic [NREQ-1:0]      Req;
  logic [5*NREQ-1:0]    ReqAddr;
  logic [32*NREQ-1:0]   ReqData;
  logic [NREQ-1:0]      Gnt;
  logic [4:0]           Awr;
  logic [31:0]          Din;
  logic                 WrEn;
  logic [4:0]           Ard1;
  logic [4:0]           Ard2;
  logic                 Hazard1;
  logic                 Hazard2;
  logic [PTRW-1:0]      Ptr;

  modport master (
    output Stall, Req, ReqAddr, ReqData, Ard1, Ard2,
    input  Gnt, Awr, Din, WrEn, Hazard1, Hazard2, Ptr
  );

  modport slave (
    input  Stall, Req, ReqAddr, ReqData, Ard1, Ard2,
    output Gnt, Awr, Din, WrEn, Hazard1, Hazard2, Ptr
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among NREQ writeback sources.
// Registered write drive, register-0 suppression and read-after-write hazard flags.
module regfile_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int PTRW = 3
) (
  input logic                Clk,
  input logic                Rst_n,
  regfile_wr_arbiter_if.slave bus
);

  logic [PTRW-1:0] ptr_q;
  logic [NREQ-1:0] gnt_p0;
  logic [PTRW-1:0] gidx_p0;
  logic            found_p0;
  logic [4:0]      addr_p0;
  logic [31:0]     data_p0;
  logic [PTRW-1:0] ptr_nxt_p0;

  logic [4:0]      awr_p1;
  logic [31:0]     din_p1;
  logic            wren_p1;

  // Stage p0: combinational round-robin search starting at ptr_q
  always_comb begin
    int idx;
    gnt_p0   = '0;
    gidx_p0  = '0;
    found_p0 = 1'b0;
    idx      = 0;
    if (Rst_n && !bus.Stall) begin
      for (int i = 0; i < NREQ; i++) begin
        idx = int'(ptr_q) + i;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!found_p0 && bus.Req[idx]) begin
          found_p0    = 1'b1;
          gidx_p0     = PTRW'(idx);
          gnt_p0[idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    addr_p0    = bus.ReqAddr[5*gidx_p0 +: 5];
    data_p0    = bus.ReqData[32*gidx_p0 +: 32];
    ptr_nxt_p0 = (gidx_p0 == PTRW'(NREQ-1)) ? '0 : gidx_p0 + 1'b1;
  end

  // Stage p1: registered drive to the register-file write port
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      awr_p1  <= '0;
      din_p1  <= '0;
      wren_p1 <= 1'b0;
      ptr_q   <= '0;
    end else if (found_p0) begin
      awr_p1  <= addr_p0;
      din_p1  <= data_p0;
      wren_p1 <= (addr_p0 != 5'd0);
      ptr_q   <= ptr_nxt_p0;
    end else begin
      wren_p1 <= 1'b0;
    end
  end

  assign bus.Gnt     = gnt_p0;
  assign bus.Awr     = awr_p1;
  assign bus.Din     = din_p1;
  assign bus.WrEn    = wren_p1;
  assign bus.Ptr     = ptr_q;
  // Register 0 never commits, so it can never be a hazard target
  assign bus.Hazard1 = wren_p1 && (awr_p1 != 5'd0) && (bus.Ard1 == awr_p1);
  assign bus.Hazard2 = wren_p1 && (awr_p1 != 5'd0) && (bus.Ard2 == awr_p1);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a small behavioural register file on the write port.
module tb_regfile_wr_arbiter;

  localparam int NREQ = 3;
  localparam int PTRW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] rf [32];

  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.NREQ(NREQ), .PTRW(PTRW)) bus ();

  regfile_wr_arbiter #(.NREQ(NREQ), .PTRW(PTRW)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) if (bus.WrEn) rf[bus.Awr] <= bus.Din;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [4:0] a, input logic [31:0] d);
    bus.ReqAddr[5*k +: 5]   = a;
    bus.ReqData[32*k +: 32] = d;
  endtask

  logic [2:0] cont_gnt [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [4:0] cont_awr [6] = '{5'd5, 5'd6, 5'd7, 5'd5, 5'd6, 5'd7};

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = '0;
    bus.Stall   = 1'b0;
    bus.Req     = 3'b001;
    bus.ReqAddr = '0;
    bus.ReqData = '0;
    bus.Ard1    = 5'd0;
    bus.Ard2    = 5'd0;

    // reset state with a request already pending
    #12;
    chk("rst_gnt",  bus.Gnt,  0);
    chk("rst_awr",  bus.Awr,  0);
    chk("rst_din",  bus.Din,  0);
    chk("rst_wren", bus.WrEn, 0);
    chk("rst_ptr",  bus.Ptr,  0);
    chk("rst_hz1",  bus.Hazard1, 0);
    bus.Req = '0;
    #2 rst_n = 1'b1;
    tick();

    // single write to r3
    set_req(0, 5'd3, 32'd32);
    bus.Req  = 3'b001;
    bus.Ard2 = 5'd3;
    #2 chk("sw_gnt", bus.Gnt, 3'b001);
    tick();
    bus.Req = '0;
    chk("sw_awr",  bus.Awr,  3);
    chk("sw_din",  bus.Din,  32);
    chk("sw_wren", bus.WrEn, 1);
    chk("sw_ptr",  bus.Ptr,  1);
    chk("sw_hz2",  bus.Hazard2, 1);
    tick();
    chk("sw_rf3",  rf[3], 32);
    chk("sw_wren_off", bus.WrEn, 0);

    // register-0 write is accepted but never enabled
    set_req(1, 5'd0, 32'd9);
    bus.Req = 3'b010;
    #2 chk("r0_gnt", bus.Gnt, 3'b010);
    tick();
    bus.Req = '0;
    chk("r0_ptr",  bus.Ptr,  2);
    chk("r0_wren", bus.WrEn, 0);
    tick();
    chk("r0_rf0",  rf[0], 0);

    // stall holds everything, pointer stays at 2
    set_req(0, 5'd20, 32'd200);
    set_req(2, 5'd22, 32'd222);
    bus.Req   = 3'b101;
    bus.Stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2 chk("st_gnt", bus.Gnt, 0);
      tick();
      chk("st_wren", bus.WrEn, 0);
      chk("st_ptr",  bus.Ptr,  2);
    end
    bus.Stall = 1'b0;
    #2 chk("st_rel_gnt", bus.Gnt, 3'b100);
    tick();
    bus.Req = '0;
    chk("st_rel_awr", bus.Awr, 22);
    chk("st_rel_ptr", bus.Ptr, 0);

    // full contention from Ptr=0
    set_req(0, 5'd5, 32'd100);
    set_req(1, 5'd6, 32'd101);
    set_req(2, 5'd7, 32'd102);
    bus.Req = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #2 chk("ct_gnt", bus.Gnt, cont_gnt[c]);
      tick();
      chk("ct_awr",  bus.Awr,  cont_awr[c]);
      chk("ct_wren", bus.WrEn, 1);
    end
    bus.Req = '0;
    tick();
    chk("ct_rf5", rf[5], 100);
    chk("ct_rf6", rf[6], 101);
    chk("ct_rf7", rf[7], 102);

    // hazard on read port 1 only
    set_req(0, 5'd10, 32'h0000abcd);
    bus.Ard1 = 5'd10;
    bus.Ard2 = 5'd3;
    bus.Req  = 3'b001;
    tick();
    bus.Req = '0;
    chk("hz_wren", bus.WrEn, 1);
    chk("hz_h1",   bus.Hazard1, 1);
    chk("hz_h2",   bus.Hazard2, 0);
    tick();
    chk("hz_h1_off", bus.Hazard1, 0);
    chk("hz_rf10",   rf[10], 32'h0000abcd);

    // asynchronous reset while a write is on the port
    set_req(1, 5'd12, 32'd77);
    bus.Req = 3'b010;
    tick();
    bus.Req = '0;
    chk("ar_wren_pre", bus.WrEn, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_wren", bus.WrEn, 0);
    chk("ar_awr",  bus.Awr,  0);
    chk("ar_din",  bus.Din,  0);
    chk("ar_ptr",  bus.Ptr,  0);
    tick();
    chk("ar_rf12", rf[12], 0);
    bus.Req = 3'b110;
    #2 rst_n = 1'b1;
    #1 chk("ar_rearb_gnt", bus.Gnt, 3'b010);
    tick();
    bus.Req = '0;
    chk("ar_rearb_ptr", bus.Ptr, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Shares the single write port (Awr/Din/WrEn) of the 32x32 register file between NREQ writeback sources, such as ALU writeback, load writeback and a multi-cycle unit. Arbitration is round-robin. Drive to the register file is registered, and register 0 writes are suppressed. Hazard flags tell the read side when a read address matches the write about to commit.

Parameters:
NREQ, 3, number of write requesters (2..8)
PTRW, 3, width of round-robin pointer; must satisfy 2**PTRW >= NREQ

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  asynchronous active-low reset
Stall  input  1  1 = grant nothing this cycle
Req  input  NREQ  per-requester write request, level
ReqAddr  input  5*NREQ  requester k address in bits [5k+4:5k]
ReqData  input  32*NREQ  requester k data in bits [32k+31:32k]
Gnt  output  NREQ  one-hot accept, combinational, same cycle as Req
Awr  output  5  register-file write address, registered
Din  output  32  register-file write data, registered
WrEn  output  1  register-file write enable, registered
Ard1  input  5  register-file read address 1 (monitored)
Ard2  input  5  register-file read address 2 (monitored)
Hazard1  output  1  Ard1 targets the write committing at next edge
Hazard2  output  1  Ard2 targets the write committing at next edge
Ptr  output  PTRW  current highest-priority requester index (debug)

Behaviour:
- Reset (Rst_n=0, async):
  - Awr=0, Din=0, WrEn=0, Ptr=0.
  - Gnt=0 and Hazard1/2=0 while Rst_n=0.
- Grant selection (combinational):
  - Search Req starting at index Ptr, ascending, wrapping at NREQ-1 -> 0.
  - The first set bit k gets Gnt[k]=1; all other Gnt bits are 0.
  - Gnt=0 when Stall=1 or Req=0.
  - Gnt is at most one-hot in every cycle.
- On rising Clk, when a grant exists:
  - Awr<=ReqAddr[k], Din<=ReqData[k].
  - WrEn<=(ReqAddr[k]!=0).
  - Ptr<=(k+1) mod NREQ.
- On rising Clk, with no grant (Stall or no Req):
  - WrEn<=0.
  - Awr, Din and Ptr hold.
- Handshake:
  - A request is consumed at the edge where its Gnt=1.
  - A requester still asserting Req afterwards posts a new, independent write.
  - A requester must keep Req/ReqAddr/ReqData stable until granted; the arbiter holds no request storage.
- Latency:
  - Accept at edge N puts Awr/Din/WrEn on the port during cycle N..N+1.
  - The register file writes at edge N+1.
  - Read data reflects the write from cycle N+1 onward.
- Register-0 writes are accepted (Gnt pulses, Ptr advances) but WrEn stays 0.
- Hazards:
  - Hazard1 = WrEn && (Awr!=0) && (Ard1==Awr); Hazard2 likewise for Ard2.
  - Both are purely combinational from registered state and read addresses.
- Fairness:
  - With all NREQ requesting continuously, grants rotate 0,1,..,NREQ-1,0.
  - No requester waits more than NREQ-1 granted cycles.
  - Stall cycles do not count toward that bound.
- Simultaneous Stall and Req: Stall wins; the pointer does not move.
- Reset mid-operation:
  - A write registered but not yet committed is dropped (WrEn forced 0 immediately).
  - Pending Req are re-arbitrated from Ptr=0 after release.
- Reset release: the first grant can occur on the first edge with Rst_n=1.
- Out-of-range (NREQ < 2**PTRW): pointer values >= NREQ never occur.

Test Plan:
- Reset then single write: Req=001, addr0=3, data0=32 -> Gnt=001 same cycle; next cycle Awr=3, Din=32, WrEn=1; following cycle Dout2 (Ard2=3)=32; Ptr=1.
- Full contention: Req=111 for 6 cycles, addresses 5/6/7 -> Gnt sequence 001,010,100,001,010,100; WrEn=1 throughout; each register written twice.
- R0 suppression: Req=010, addr1=0, data1=9 -> Gnt=010, Ptr=2, WrEn=0; register 0 still reads 0.
- Stall: Req=101 with Stall=1 for 3 cycles -> Gnt=000, WrEn=0, Ptr unchanged; on Stall=0, Gnt=001 if Ptr=0.
- Hazard: grant write to reg 10 with Ard1=10, Ard2=3 -> in the cycle WrEn=1, Hazard1=1, Hazard2=0; next cycle Hazard1=0 and Dout1 = new data.
- Async reset mid-write: assert Rst_n=0 between edges while WrEn=1 -> WrEn, Awr, Din, Ptr go 0 without a clock edge; target register keeps its old value.
